// File: rtl/tcm_pkg.sv
// Shared definitions for the external TCM access port: FSM states, size codes
// and the ITCM/DTCM window select values (overridable via ITCM_BASE/DTCM_BASE).
`ifndef ITCM_BASE
`define ITCM_BASE 8'h10
`endif
`ifndef DTCM_BASE
`define DTCM_BASE 8'h20
`endif

package tcm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] ITCM_SEL_DEF = `ITCM_BASE;
  localparam logic [7:0] DTCM_SEL_DEF = `DTCM_BASE;

  // Natural alignment check; size 3 is never legal.
  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return !lo[0];
      SZ_W:    return lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tcm_ext_lane.sv
// Combinational byte-lane steering: write byte enables and data replication,
// and read-data extraction with zero extension.
module tcm_ext_lane
  import tcm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  ben,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    shifted    = rdata_raw >> {lo, 3'b000};
    ben        = 4'h0;
    wdata_lane = '0;
    rdata_ext  = '0;
    case (size)
      SZ_B: begin
        ben        = 4'b0001 << lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {24'h0, shifted[7:0]};
      end
      SZ_H: begin
        ben        = 4'b0011 << lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {16'h0, shifted[15:0]};
      end
      SZ_W: begin
        ben        = 4'hF;
        wdata_lane = wdata;
        rdata_ext  = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tcm_ext_port.sv
// External host port into ITCM/DTCM: one access per request, issued only when the
// core leaves the TCM idle. TCM_EXT_STARVE_EN adds the starvation counter and core_hold.
module tcm_ext_port
  import tcm_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 15,
  parameter logic [7:0]  ITCM_SEL     = ITCM_SEL_DEF,
  parameter logic [7:0]  DTCM_SEL     = DTCM_SEL_DEF
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        ext_req_valid,
  output logic        ext_req_ready,
  input  logic        ext_req_we,
  input  logic [1:0]  ext_req_size,
  input  logic [31:0] ext_req_addr,
  input  logic [31:0] ext_req_wdata,
  output logic        ext_rsp_valid,
  input  logic        ext_rsp_ready,
  output logic [31:0] ext_rsp_rdata,
  output logic        ext_rsp_err,
  input  logic        core_tcm_busy,
  output logic        core_hold,
  output logic        tcm_cs,
  output logic        tcm_we,
  output logic        tcm_sel_i,
  output logic [31:0] tcm_addr,
  output logic [3:0]  tcm_ben,
  output logic [31:0] tcm_wdata,
  input  logic [31:0] tcm_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("STARVE_LIMIT must be in 1..15");
  end

  state_e      state;
  logic [1:0]  req_size;
  logic [1:0]  req_lo;
  logic [1:0]  lane_size;
  logic [1:0]  lane_lo;
  logic [3:0]  lane_ben;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        in_itcm;
  logic        in_dtcm;
  logic        dec_ok;

  assign in_itcm = ext_req_addr[31:24] == ITCM_SEL;
  assign in_dtcm = ext_req_addr[31:24] == DTCM_SEL;
  assign dec_ok  = (in_itcm || in_dtcm) && size_aligned(ext_req_size, ext_req_addr[1:0]);

  // The lane unit serves the live request while idle and the latched one afterwards.
  assign lane_size = (state == IDLE) ? ext_req_size      : req_size;
  assign lane_lo   = (state == IDLE) ? ext_req_addr[1:0] : req_lo;

  tcm_ext_lane u_lane (
    .size       (lane_size),
    .lo         (lane_lo),
    .wdata      (ext_req_wdata),
    .rdata_raw  (tcm_rdata),
    .ben        (lane_ben),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  assign ext_req_ready = state == IDLE;
  assign ext_rsp_valid = state == RESP;
  // A core access always wins the cycle it is present.
  assign tcm_cs        = (state == ISSUE) && !core_tcm_busy;

  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      state         <= IDLE;
      req_size      <= SZ_B;
      req_lo        <= 2'b00;
      ext_rsp_rdata <= '0;
      ext_rsp_err   <= 1'b0;
      tcm_we        <= 1'b0;
      tcm_sel_i     <= 1'b0;
      tcm_addr      <= '0;
      tcm_ben       <= 4'h0;
      tcm_wdata     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      case (state)
        IDLE: if (ext_req_valid) begin
          req_size      <= ext_req_size;
          req_lo        <= ext_req_addr[1:0];
          ext_rsp_rdata <= '0;
          if (!dec_ok) begin
            ext_rsp_err <= 1'b1;
            state       <= RESP;
          end else begin
            ext_rsp_err <= 1'b0;
            tcm_we      <= ext_req_we;
            tcm_sel_i   <= in_itcm;
            tcm_addr    <= {ext_req_addr[31:2], 2'b00};
            tcm_ben     <= ext_req_we ? lane_ben   : 4'h0;
            tcm_wdata   <= ext_req_we ? lane_wdata : '0;
            state       <= ISSUE;
          end
        end
        ISSUE: if (!core_tcm_busy) begin
          state     <= tcm_we ? RESP : RDATA;
          tcm_we    <= 1'b0;
          tcm_sel_i <= 1'b0;
          tcm_addr  <= '0;
          tcm_ben   <= 4'h0;
          tcm_wdata <= '0;
        end
        RDATA: begin
          ext_rsp_rdata <= lane_rdata;
          state         <= RESP;
        end
        RESP: if (ext_rsp_ready) begin
          ext_rsp_rdata <= '0;
          ext_rsp_err   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TCM_EXT_STARVE_EN
  logic [3:0] starve_cnt;
  logic [3:0] cnt_inc;
  logic       hold_q;

  assign cnt_inc   = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
  assign core_hold = hold_q;

  // Counter restarts for every request; hold asserts once the limit of denied cycles is hit.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      starve_cnt <= 4'h0;
      hold_q     <= 1'b0;
    end else if (state == IDLE) begin
      starve_cnt <= 4'h0;
      hold_q     <= 1'b0;
    end else if (state == ISSUE) begin
      if (core_tcm_busy) begin
        starve_cnt <= cnt_inc;
        if (cnt_inc >= 4'(STARVE_LIMIT)) hold_q <= 1'b1;
      end else begin
        hold_q <= 1'b0;
      end
    end
  end
`else
  assign core_hold = 1'b0;
`endif

endmodule

// File: tb/tb_tcm_ext_port.sv
// Scoreboard bench for tcm_ext_port: a byte-level memory model predicts responses and
// TCM strobes; monitors compare whenever the DUT presents a response or a strobe.
`timescale 1ns/1ps
module tb_tcm_ext_port;

  localparam logic [7:0] ISEL = tcm_pkg::ITCM_SEL_DEF;
  localparam logic [7:0] DSEL = tcm_pkg::DTCM_SEL_DEF;
  localparam logic [7:0] BSEL = (ISEL != 8'hFF && DSEL != 8'hFF) ? 8'hFF :
                                (ISEL != 8'hFE && DSEL != 8'hFE) ? 8'hFE : 8'hFD;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        ext_req_valid, ext_req_ready, ext_req_we;
  logic [1:0]  ext_req_size;
  logic [31:0] ext_req_addr, ext_req_wdata;
  logic        ext_rsp_valid, ext_rsp_ready, ext_rsp_err;
  logic [31:0] ext_rsp_rdata;
  logic        core_tcm_busy, core_hold;
  logic        tcm_cs, tcm_we, tcm_sel_i;
  logic [31:0] tcm_addr, tcm_wdata, tcm_rdata;
  logic [3:0]  tcm_ben;

  always #5 clk = ~clk;

  tcm_ext_port #(.STARVE_LIMIT(15)) dut (
    .clk(clk), .cpurst(cpurst),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_req_we(ext_req_we),
    .ext_req_size(ext_req_size), .ext_req_addr(ext_req_addr), .ext_req_wdata(ext_req_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready),
    .ext_rsp_rdata(ext_rsp_rdata), .ext_rsp_err(ext_rsp_err),
    .core_tcm_busy(core_tcm_busy), .core_hold(core_hold),
    .tcm_cs(tcm_cs), .tcm_we(tcm_we), .tcm_sel_i(tcm_sel_i), .tcm_addr(tcm_addr),
    .tcm_ben(tcm_ben), .tcm_wdata(tcm_wdata), .tcm_rdata(tcm_rdata)
  );

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic we; logic sel; logic [31:0] addr; logic [3:0] ben; logic [31:0] wdata; } stb_t;

  rsp_t        rsp_q[$];
  stb_t        stb_q[$];
  logic [7:0]  ref_mem [0:1][0:63];
  logic [31:0] env_mem [0:31];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: decode from the address map, then move bytes through a flat byte array.
  task automatic push_expect(input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
    rsp_t r;
    stb_t s;
    int   n     = 1 << size;
    bit   is_i  = addr[31:24] == ISEL;
    bit   ok    = (is_i || addr[31:24] == DSEL) && size != 2'd3 && (addr % n) == 0;
    int   off   = int'(addr[5:0]);
    int   lane0 = int'(addr % 4);
    r.rdata = '0;
    r.err   = !ok;
    if (ok) begin
      s.we = we; s.sel = is_i; s.addr = addr & ~32'h3; s.ben = '0; s.wdata = '0;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[is_i][off + i] = wdata[8*i +: 8];
        for (int l = 0; l < 4; l++) begin
          s.ben[l]          = (l >= lane0) && (l < lane0 + n);
          s.wdata[8*l +: 8] = wdata[8*(l % n) +: 8];
        end
      end else begin
        for (int i = 0; i < n; i++) r.rdata[8*i +: 8] = ref_mem[is_i][off + i];
      end
      stb_q.push_back(s);
    end
    rsp_q.push_back(r);
  endtask

  // TCM responder: read data appears the cycle after a read strobe, noise otherwise.
  always @(posedge clk) begin
    if (tcm_cs && !tcm_we) tcm_rdata <= env_mem[{tcm_sel_i, tcm_addr[5:2]}];
    else                   tcm_rdata <= $urandom;
    if (tcm_cs && tcm_we)
      for (int l = 0; l < 4; l++)
        if (tcm_ben[l]) env_mem[{tcm_sel_i, tcm_addr[5:2]}][8*l +: 8] <= tcm_wdata[8*l +: 8];
  end

  rsp_t mon_r;
  stb_t mon_s;
  always @(negedge clk) begin
    if (!cpurst && ext_rsp_valid && ext_rsp_ready) begin
      if (rsp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: got response rdata 0x%08h err %0b, expected none",
                 ext_rsp_rdata, ext_rsp_err);
      end else begin
        mon_r = rsp_q.pop_front();
        check("rsp_rdata", ext_rsp_rdata, mon_r.rdata);
        check("rsp_err", 32'(ext_rsp_err), 32'(mon_r.err));
      end
    end
    if (!cpurst && tcm_cs) begin
      check("cs_while_busy", 32'(core_tcm_busy), 32'd0);
      if (stb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL stb_unexpected: got tcm_cs addr 0x%08h we %0b, expected none", tcm_addr, tcm_we);
      end else begin
        mon_s = stb_q.pop_front();
        check("stb_we", 32'(tcm_we), 32'(mon_s.we));
        check("stb_sel", 32'(tcm_sel_i), 32'(mon_s.sel));
        check("stb_addr", tcm_addr, mon_s.addr);
        check("stb_ben", 32'(tcm_ben), 32'(mon_s.ben));
        check("stb_wdata", tcm_wdata, mon_s.wdata);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns cycle indices relative to the accept edge.
  task automatic xact(input logic we, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input int busy_len, input bit rnd,
                      output int cs_at, output int rsp_at, output int hold_rise, output int hold_fall);
    bit done = 0;
    cs_at = -1; rsp_at = -1; hold_rise = -1; hold_fall = -1;
    push_expect(we, size, addr, wdata);
    ext_req_valid = 1'b1; ext_req_we = we; ext_req_size = size;
    ext_req_addr = addr; ext_req_wdata = wdata; ext_rsp_ready = 1'b1;
    for (int w = 0; w < 20 && !ext_req_ready; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    for (int k = 1; k <= 300; k++) begin
      ext_req_valid = rnd && ($urandom_range(0, 1) == 1);
      ext_req_we    = 1'($urandom); ext_req_size = 2'($urandom);
      ext_req_addr  = {DSEL, 24'($urandom)}; ext_req_wdata = $urandom;
      core_tcm_busy = (k <= busy_len) || (rnd && $urandom_range(0, 3) == 0);
      ext_rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (tcm_cs && cs_at < 0) cs_at = k;
      if (ext_rsp_valid && rsp_at < 0) rsp_at = k;
      if (core_hold && hold_rise < 0) hold_rise = k;
      if (!core_hold && hold_rise > 0 && hold_fall < 0) hold_fall = k;
      if (ext_rsp_valid && ext_rsp_ready) begin
        done = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    ext_req_valid = 1'b0; core_tcm_busy = 1'b0; ext_rsp_ready = 1'b1;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL xact_timeout: got no response for addr 0x%08h, expected one within 300 cycles", addr);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(ext_req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(ext_rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, ext_rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, 32'(ext_rsp_err), 32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_tcm_strobes"}, {28'd0, tcm_cs, tcm_we, tcm_sel_i, 1'b0}, 32'd0);
    check({tag, "_tcm_addr"}, tcm_addr, 32'd0);
    check({tag, "_tcm_ben"}, 32'(tcm_ben), 32'd0);
    check({tag, "_tcm_wdata"}, tcm_wdata, 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got simulation still running, expected completion before 500us");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cs_at, rsp_at, h_rise, h_fall, cs_cnt;
    for (int b = 0; b < 2; b++) for (int i = 0; i < 64; i++) ref_mem[b][i] = 8'h00;
    for (int i = 0; i < 32; i++) env_mem[i] = 32'h0;
    cpurst = 1'b1; ext_req_valid = 1'b0; ext_req_we = 1'b0; ext_req_size = 2'd0;
    ext_req_addr = '0; ext_req_wdata = '0; ext_rsp_ready = 1'b1; core_tcm_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #1 cpurst = 1'b0;
    @(posedge clk); #1;

    // Word write then read back, core idle.
    xact(1'b1, 2'd2, {DSEL, 24'h000010}, 32'hDEADBEEF, 0, 0, cs_at, rsp_at, h_rise, h_fall);
    check("wr_word_cs_cycle", cs_at, 1);
    check("wr_word_rsp_cycle", rsp_at, 2);
    xact(1'b0, 2'd2, {DSEL, 24'h000010}, 32'h0, 0, 0, cs_at, rsp_at, h_rise, h_fall);
    check("rd_word_cs_cycle", cs_at, 1);
    check("rd_word_rsp_cycle", rsp_at, 3);

    // Byte lane 3 write and read.
    xact(1'b1, 2'd0, {DSEL, 24'h000013}, 32'h000000A5, 0, 0, cs_at, rsp_at, h_rise, h_fall);
    xact(1'b0, 2'd0, {DSEL, 24'h000013}, 32'h0, 0, 0, cs_at, rsp_at, h_rise, h_fall);
    check("rd_byte_rsp_cycle", rsp_at, 3);

    // Decode errors: misaligned half and address outside both windows.
    xact(1'b0, 2'd1, {DSEL, 24'h000001}, 32'h0, 0, 0, cs_at, rsp_at, h_rise, h_fall);
    check("err_misalign_cs", cs_at, -1);
    check("err_misalign_rsp_cycle", rsp_at, 1);
    xact(1'b1, 2'd2, {BSEL, 24'h000010}, 32'h12345678, 0, 0, cs_at, rsp_at, h_rise, h_fall);
    check("err_window_cs", cs_at, -1);
    check("err_window_rsp_cycle", rsp_at, 1);

    // Core busy for 20 cycles in front of a write.
    xact(1'b1, 2'd2, {ISEL, 24'h000020}, 32'hCAFEF00D, 20, 0, cs_at, rsp_at, h_rise, h_fall);
    check("starve_grant_cycle", cs_at, 21);
    check("starve_rsp_cycle", rsp_at, 22);
`ifdef TCM_EXT_STARVE_EN
    check("starve_hold_rise", h_rise, 16);
    check("starve_hold_fall", h_fall, 22);
`else
    check("starve_hold_never", h_rise, -1);
`endif
    xact(1'b0, 2'd1, {ISEL, 24'h000022}, 32'h0, 0, 0, cs_at, rsp_at, h_rise, h_fall);

    // Reset while a write waits in ISSUE: nothing may follow.
    ext_req_valid = 1'b1; ext_req_we = 1'b1; ext_req_size = 2'd2;
    ext_req_addr = {DSEL, 24'h000030}; ext_req_wdata = 32'h55AA55AA; core_tcm_busy = 1'b1;
    @(posedge clk); #1 ext_req_valid = 1'b0;
    @(posedge clk); #1 cpurst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    core_tcm_busy = 1'b0;
    @(posedge clk); #1 cpurst = 1'b0;
    cs_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (tcm_cs || ext_rsp_valid) cs_cnt++;
    end
    check("post_reset_activity", cs_cnt, 0);
    check("post_reset_ready", 32'(ext_req_ready), 32'd1);
    xact(1'b0, 2'd2, {DSEL, 24'h000030}, 32'h0, 0, 0, cs_at, rsp_at, h_rise, h_fall);

    // Randomized traffic with contention, back-pressure and ignored requests.
    for (int t = 0; t < 200; t++) begin
      int          pick = $urandom_range(0, 19);
      logic [7:0]  sel  = (pick < 9) ? ISEL : (pick < 18) ? DSEL : BSEL;
      logic [1:0]  sz   = (pick == 19) ? 2'd3 : 2'($urandom_range(0, 2));
      logic [31:0] addr = {sel, 18'h0, 6'($urandom)};
      if ($urandom_range(0, 4) != 0)
        addr[1:0] = (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
      xact(1'($urandom), sz, addr, $urandom, 0, 1, cs_at, rsp_at, h_rise, h_fall);
    end

    repeat (3) @(posedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("stb_queue_drained", stb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tcm_ext_port.md
# tcm_ext_port

External host access port into the tightly-coupled memories. It accepts single read/write requests from an off-core initiator (loader, debugger, DMA), checks them against the ITCM/DTCM windows and waits for the core's load/store port to leave the TCM idle. It then performs exactly one 32-bit-lane SRAM access and returns a response. It is the responder/target counterpart of the core's TCM initiator path and sits beside that path in front of the isram/dsram muxes.

## Interface
Parameters:
- STARVE_LIMIT, 15: consecutive denied cycles before the block forces a core hold (4-bit counter; must be 1..15).
- ITCM_SEL, `ITCM_BASE: value of addr[31:24] selecting ITCM.
- DTCM_SEL, `DTCM_BASE: value of addr[31:24] selecting DTCM.

Ports:
- clk  in  1  clock; the block uses one clock.
- cpurst  in  1  reset; asynchronous, active-high.
- ext_req_valid  in  1  host request valid.
- ext_req_ready  out  1  block can accept a request.
- ext_req_we  in  1  1 = write, 0 = read.
- ext_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- ext_req_addr  in  32  byte address.
- ext_req_wdata  in  32  write data, right-aligned.
- ext_rsp_valid  out  1  response valid.
- ext_rsp_ready  in  1  host accepts the response.
- ext_rsp_rdata  out  32  read data, zero-extended; 0 for writes and errors.
- ext_rsp_err  out  1  access rejected.
- core_tcm_busy  in  1  core is driving a TCM access this cycle.
- core_hold  out  1  stall request to the core.
- tcm_cs, tcm_we  out  1 each  TCM strobes.
- tcm_sel_i  out  1  1 = ITCM, 0 = DTCM.
- tcm_addr  out  32  word address (bits [1:0] = 0).
- tcm_ben  out  4  byte enables.
- tcm_wdata  out  32  lane-aligned write data.
- tcm_rdata  in  32  read data, valid the cycle after a read strobe.

## Operation
- FSM states: IDLE, ISSUE, RDATA, RESP.
- IDLE
  - ext_req_ready = 1.
  - On valid & ready, latch we/size/addr/wdata and decode the request.
  - If decode fails, go to RESP with err = 1. Decode fails when: addr[31:24] matches neither window; size = 3; size 1 with addr[0] = 1; or size 2 with addr[1:0] != 0.
  - Otherwise go to ISSUE.
- ISSUE
  - tcm_cs = !core_tcm_busy (combinational). All other tcm_* outputs come from registers.
  - On a cycle where the grant occurs: a write goes to RESP; a read goes to RDATA.
- RDATA
  - Capture (tcm_rdata >> 8*addr[1:0]), masked to the access size, into ext_rsp_rdata.
  - Go to RESP.
- RESP
  - ext_rsp_valid = 1, held with stable data until ext_rsp_ready. Then go to IDLE.
- Lane rules:
  - byte: ben = 1<<addr[1:0], wdata replicated ×4.
  - half: ben = 3<<addr[1:0], wdata replicated ×2.
  - word: ben = 4'hF.
- tcm_ben and tcm_wdata are forced to 0 when tcm_we = 0.
- Starvation counter:
  - Cleared on entry to ISSUE.
  - Increments, saturating, each ISSUE cycle with core_tcm_busy = 1.
  - core_hold is registered. It goes to 1 the cycle after the counter reaches STARVE_LIMIT and clears the cycle after the grant.
- Simultaneous events:
  - A core access always wins the same cycle.
  - ext_req_valid in a non-IDLE state is ignored (ready = 0).

## Timing
- Reset values: state IDLE; ext_req_ready 1; ext_rsp_valid 0; ext_rsp_rdata 0; ext_rsp_err 0; core_hold 0; all tcm_* 0; counter 0.
- Reset mid-transaction drops the transaction. No response is produced and no partial TCM write occurs after reset assertion.
- Latency with no contention, request accepted at edge N:
  - read: tcm_cs in cycle N+1, data sampled in N+2, ext_rsp_valid in N+3.
  - write: tcm_cs in N+1, ext_rsp_valid in N+2.
  - error: ext_rsp_valid in N+1.
- Back-to-back throughput: one request per 3 cycles (write) or 4 cycles (read) with ext_rsp_ready held at 1.

## Configuration
- TCM_EXT_STARVE_EN defined: starvation counter and core_hold are present as described above.
- TCM_EXT_STARVE_EN undefined: no counter; core_hold is tied to 0; ISSUE waits indefinitely for core_tcm_busy = 0.

## Structure
- Shared package tcm_pkg holds:
  - state encoding;
  - size codes (SZ_B, SZ_H, SZ_W);
  - ITCM/DTCM select constants.
- One sub-module, tcm_ext_lane, is combinational. It generates ben and wdata alignment and performs rdata extraction/zero-extension. The FSM, counter and registers stay in tcm_ext_port.

## Test plan
- Word write then read at DTCM_SEL<<24 | 0x10, data 0xDEADBEEF, core idle:
  - write: tcm_cs at N+1 with ben F, rsp at N+2;
  - read: rsp at N+3 with rdata 0xDEADBEEF and err 0.
- Byte write 0xA5 to offset 0x13:
  - required: ben 4'b1000, tcm_wdata 0xA5A5A5A5.
  - Read back of tcm_rdata 0xA5000000 returns 0x000000A5.
- Misaligned half at addr 0x...01, and an address outside both windows:
  - required: err 1, rdata 0, rsp at N+1, tcm_cs never asserted.
- core_tcm_busy held at 1 for 20 cycles, STARVE_LIMIT = 15, macro on:
  - required: core_hold rises after 15 denied cycles; grant occurs on the first busy = 0 cycle; core_hold falls the next cycle.
- Same contention with the macro off:
  - required: core_hold stays 0; the access is issued only after busy drops.
- cpurst pulsed during ISSUE of a write:
  - required: no tcm_cs afterwards, no response, all outputs at their reset values, ready = 1 after release.
